// File: rtl/tsv_sum_pkg.sv
// rtl/tsv_sum_pkg.sv - shared FSM states and lane-index helpers for the TSV sum link
package tsv_sum_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_RECONF = 2'd2
  } link_state_e;

  // Logical lane 0..data_w-1 carries the result; the three lanes above it are fixed roles.
  function automatic int parity_lane(input int data_w);
    return data_w;
  endfunction

  function automatic int valid_lane(input int data_w);
    return data_w + 1;
  endfunction

  function automatic int spare_lane(input int data_w);
    return data_w + 2;
  endfunction

endpackage

// File: rtl/tsv_sum_cell.sv
// rtl/tsv_sum_cell.sv - one TSV driver cell, a single physical lane
module tsv_sum_cell (
  input  logic lane_in,
  output logic lane_out
);

  assign lane_out = lane_in;

endmodule

// File: rtl/tsv_sum_fifo.sv
// rtl/tsv_sum_fifo.sv - result FIFO; a pop never frees space for a same-cycle push
module tsv_sum_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [W-1:0]               push_data,
  input  logic                       pop,
  output logic [W-1:0]               head_data,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          push_ok, pop_ok;

  assign full      = (cnt_q == CW'(DEPTH));
  assign empty     = (cnt_q == '0);
  assign level     = cnt_q;
  assign head_data = mem_q[rd_q];
  assign push_ok   = push && !full;
  assign pop_ok    = pop && !empty;

  // Pointer, count and storage updates for the coming edge.
  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (push_ok) begin
      mem_d[wr_q] = push_data;
      wr_d        = wr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_d = rd_q + 1'b1;
    end
    if (push_ok && !pop_ok) begin
      cnt_d = cnt_q + 1'b1;
    end else if (!push_ok && pop_ok) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Pointers and count clear on reset, which discards any queued words.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset: the count decides which entries are live.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/tsv_sum_link.sv
// rtl/tsv_sum_link.sv - add/sub datapath feeding a lane-repairable TSV link
module tsv_sum_link
  import tsv_sum_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DATA_W-1:0]            input1,
  input  logic [DATA_W-1:0]            input2,
  input  logic                         op_sub,
  input  logic                         link_ready,
  input  logic                         cfg_update,
  input  logic                         cfg_repair_en,
  input  logic [$clog2(DATA_W+3)-1:0]  cfg_fault_lane,
  output logic [DATA_W+2:0]            output1,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_level,
  output logic                         busy
);

  localparam int VLD_LANE = valid_lane(DATA_W);
  localparam int SPR_LANE = spare_lane(DATA_W);
  localparam int NLOG     = VLD_LANE + 1;
  localparam int NPHYS    = SPR_LANE + 1;
  localparam int LW       = $clog2(DATA_W+3);

  link_state_e       state_q, state_d;
  logic              ready_en_q, ready_en_d;
  logic [NLOG-1:0]   launch_q, launch_d;
  logic              act_en_q, act_en_d, pend_en_q, pend_en_d;
  logic [LW-1:0]     act_lane_q, act_lane_d, pend_lane_q, pend_lane_d;

  logic [DATA_W-1:0] result, fifo_head;
  logic              fifo_full, fifo_empty, push, pop;
  logic [NPHYS-1:0]  log_ext, log_shift, phys_lanes;
  logic              repair_on;

  assign push     = in_valid && in_ready;
  assign pop      = !fifo_empty && link_ready;
  assign in_ready = ready_en_q && (state_q == ST_RUN) && !fifo_full;
  assign busy     = (state_q != ST_RUN);

  // Operation result wraps to DATA_W bits; carry and borrow are dropped.
  always_comb begin
    result = op_sub ? (input1 - input2) : (input1 + input2);
  end

  tsv_sum_fifo #(
    .W     (DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (result),
    .pop       (pop),
    .head_data (fifo_head),
    .level     (fifo_level),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Launch register and reconfiguration FSM: drain under the old map, then swap maps.
  always_comb begin
    state_d            = state_q;
    ready_en_d         = 1'b1;
    launch_d           = launch_q;
    launch_d[VLD_LANE] = 1'b0;
    act_en_d           = act_en_q;
    act_lane_d         = act_lane_q;
    pend_en_d          = pend_en_q;
    pend_lane_d        = pend_lane_q;
    if (pop) begin
      launch_d = {1'b1, ^fifo_head, fifo_head};
    end
    case (state_q)
      ST_RUN: begin
        if (cfg_update) begin
          state_d     = ST_DRAIN;
          pend_en_d   = cfg_repair_en;
          pend_lane_d = cfg_fault_lane;
        end
      end
      ST_DRAIN: begin
        if (fifo_empty && !launch_q[VLD_LANE]) begin
          state_d  = ST_RECONF;
          launch_d = '0;
        end
      end
      ST_RECONF: begin
        state_d    = ST_RUN;
        act_en_d   = pend_en_q;
        act_lane_d = pend_lane_q;
      end
      default: state_d = ST_RUN;
    endcase
  end

  // State register; in_ready stays low until the first edge out of reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      ready_en_q  <= 1'b0;
      launch_q    <= '0;
      act_en_q    <= 1'b0;
      act_lane_q  <= '0;
      pend_en_q   <= 1'b0;
      pend_lane_q <= '0;
    end else begin
      state_q     <= state_d;
      ready_en_q  <= ready_en_d;
      launch_q    <= launch_d;
      act_en_q    <= act_en_d;
      act_lane_q  <= act_lane_d;
      pend_en_q   <= pend_en_d;
      pend_lane_q <= pend_lane_d;
    end
  end

  // Lane remap: skip the faulty physical lane and push everything above it up by one.
  always_comb begin
    log_ext    = {1'b0, launch_q};
    log_shift  = {launch_q, 1'b0};
    repair_on  = act_en_q && (int'(act_lane_q) <= VLD_LANE);
    phys_lanes = log_ext;
    if (repair_on) begin
      for (int p = 0; p < NPHYS; p++) begin
        if (p > int'(act_lane_q)) begin
          phys_lanes[p] = log_shift[p];
        end else if (p == int'(act_lane_q)) begin
          phys_lanes[p] = 1'b0;
        end
      end
    end
  end

  for (genvar g = 0; g < NPHYS; g++) begin : g_tsv
    tsv_sum_cell u_cell (
      .lane_in  (phys_lanes[g]),
      .lane_out (output1[g])
    );
  end

endmodule

// File: tb/tb_tsv_sum_link.sv
// tb/tb_tsv_sum_link.sv - self-checking bench for tsv_sum_link
module tb_tsv_sum_link;

  localparam int DATA_W   = 8;
  localparam int DEPTH    = 4;
  localparam int P_RUN    = 0;
  localparam int P_DRAIN  = 1;
  localparam int P_RECONF = 2;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, op_sub, link_ready, cfg_update, cfg_repair_en;
  logic [7:0]  input1, input2;
  logic [3:0]  cfg_fault_lane;
  logic        in_ready, busy;
  logic [10:0] output1;
  logic [2:0]  fifo_level;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  tsv_sum_link #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .input1         (input1),
    .input2         (input2),
    .op_sub         (op_sub),
    .link_ready     (link_ready),
    .cfg_update     (cfg_update),
    .cfg_repair_en  (cfg_repair_en),
    .cfg_fault_lane (cfg_fault_lane),
    .output1        (output1),
    .fifo_level     (fifo_level),
    .busy           (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Physical lanes from a logical word: bits below k stay, bits from k up move up one.
  function automatic logic [10:0] map_fn(input logic [9:0] lw, input bit en, input int k);
    logic [10:0] ext, lo, hi;
    ext = {1'b0, lw};
    if (!en || k > DATA_W + 1) return ext;
    lo = ext & ((11'd1 << k) - 11'd1);
    hi = (ext >> k) << (k + 1);
    return lo | hi;
  endfunction

  logic [7:0] m_q[$];
  int         m_phase, m_act_k, m_pend_k, m_sz;
  bit         m_ok = 1'b0;
  bit         m_rdy, m_act_en, m_pend_en, m_lv, m_acc;
  logic [9:0] m_launch;
  logic [7:0] m_res, m_d;

  // Behavioural model, advanced once per rising edge from the sampled inputs.
  initial begin
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        m_q.delete();
        m_phase   = P_RUN;
        m_act_en  = 1'b0;
        m_act_k   = 0;
        m_pend_en = 1'b0;
        m_pend_k  = 0;
        m_launch  = '0;
        m_rdy     = 1'b0;
        m_ok      = 1'b1;
      end else begin
        m_sz  = m_q.size();
        m_lv  = m_launch[9];
        m_acc = in_valid && m_rdy && (m_phase == P_RUN) && (m_sz < DEPTH);
        m_res = op_sub ? input1 - input2 : input1 + input2;
        if (m_sz > 0 && link_ready) begin
          m_d      = m_q.pop_front();
          m_launch = {1'b1, (($countones(m_d) % 2) == 1), m_d};
        end else begin
          m_launch[9] = 1'b0;
        end
        if (m_phase == P_RUN) begin
          if (cfg_update) begin
            m_phase   = P_DRAIN;
            m_pend_en = cfg_repair_en;
            m_pend_k  = int'(cfg_fault_lane);
          end
        end else if (m_phase == P_DRAIN) begin
          if (m_sz == 0 && !m_lv) begin
            m_phase  = P_RECONF;
            m_launch = '0;
          end
        end else begin
          m_phase  = P_RUN;
          m_act_en = m_pend_en;
          m_act_k  = m_pend_k;
        end
        if (m_acc) m_q.push_back(m_res);
        m_rdy = 1'b1;
      end
    end
  end

  // Compare all outputs against the model on every falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (m_ok) begin
        check("mon_output1", output1, map_fn(m_launch, m_act_en, m_act_k));
        check("mon_in_ready", in_ready, m_rdy && (m_phase == P_RUN) && (m_q.size() < DEPTH));
        check("mon_fifo_level", fifo_level, m_q.size());
        check("mon_busy", busy, m_phase != P_RUN);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; input1 = '0; input2 = '0; op_sub = 1'b0;
    link_ready = 1'b0; cfg_update = 1'b0; cfg_repair_en = 1'b0; cfg_fault_lane = '0;
    repeat (3) tick();
    check("rst_output1", output1, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_level", fifo_level, 0);
    rst_n = 1'b1;
    tick();
    check("rise_in_ready", in_ready, 1);

    // 0x3C + 0x05
    in_valid = 1'b1; input1 = 8'h3C; input2 = 8'h05; link_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    check("add_launch", output1, 11'h241);
    tick();
    check("add_hold", output1, 11'h041);

    // subtract with borrow, then add with carry out
    in_valid = 1'b1; input1 = 8'h02; input2 = 8'h05; op_sub = 1'b1;
    tick();
    input1 = 8'hFF; input2 = 8'h01; op_sub = 1'b0;
    tick();
    in_valid = 1'b0;
    check("sub_launch", output1, 11'h3FD);
    tick();
    check("wrap_launch", output1, 11'h200);
    tick();
    check("idle_hold", output1, 11'h000);

    // fill with the link stalled, fifth word refused
    link_ready = 1'b0; in_valid = 1'b1; input2 = 8'h01;
    for (int i = 1; i <= 5; i++) begin
      input1 = 8'(8'h11 * i);
      tick();
    end
    in_valid = 1'b0;
    check("full_level", fifo_level, 4);
    check("full_in_ready", in_ready, 0);
    link_ready = 1'b1;
    tick();
    check("first_out", output1, 11'h212);
    repeat (5) tick();

    // reconfigure to fault lane 3 with three words queued
    link_ready = 1'b0; in_valid = 1'b1; input2 = 8'h00;
    for (int i = 0; i < 3; i++) begin
      input1 = 8'(8'h21 + i);
      tick();
    end
    in_valid = 1'b0; cfg_update = 1'b1; cfg_repair_en = 1'b1; cfg_fault_lane = 4'd3; link_ready = 1'b1;
    tick();
    check("drain_busy", busy, 1);
    check("drain_first", output1, 11'h221);
    cfg_update = 1'b0;
    tick();
    cfg_update = 1'b1; cfg_repair_en = 1'b0;
    tick();
    cfg_update = 1'b0;
    tick();
    tick();
    check("reconf_zero", output1, 11'h000);
    check("reconf_busy", busy, 1);
    tick();
    check("run_again", busy, 0);
    in_valid = 1'b1; input1 = 8'h08; input2 = 8'h00;
    tick();
    in_valid = 1'b0;
    tick();
    check("repaired", output1, 11'h610);
    tick();

    // push together with cfg_update; new map uses an out-of-range fault lane
    in_valid = 1'b1; input1 = 8'h80; input2 = 8'h01;
    cfg_update = 1'b1; cfg_repair_en = 1'b1; cfg_fault_lane = 4'd10;
    tick();
    in_valid = 1'b0; cfg_update = 1'b0;
    tick();
    check("old_map_drain", output1, 11'h501);
    repeat (3) tick();
    in_valid = 1'b1; input1 = 8'h0F; input2 = 8'h00;
    tick();
    in_valid = 1'b0;
    tick();
    check("bad_lane_unshifted", output1, 11'h20F);

    // reset while draining
    link_ready = 1'b0; in_valid = 1'b1; input1 = 8'h01; input2 = 8'h01;
    repeat (2) tick();
    in_valid = 1'b0; cfg_update = 1'b1; cfg_repair_en = 1'b1; cfg_fault_lane = 4'd5;
    tick();
    cfg_update = 1'b0;
    tick();
    check("in_drain", busy, 1);
    rst_n = 1'b0;
    tick();
    check("mid_rst_output1", output1, 0);
    check("mid_rst_level", fifo_level, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_in_ready", in_ready, 0);
    rst_n = 1'b1;
    tick();
    check("mid_rst_rise", in_ready, 1);
    in_valid = 1'b1; input1 = 8'h3C; input2 = 8'h05; link_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    check("post_rst_map", output1, 11'h241);
    repeat (2) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
